// File: rtl/fp_encoder_pipe.sv
// Streaming two's-complement to sign/exponent/significand encoder, 3-stage pipeline
// with global stall. Define FPENC_ROUND_EN for round-to-nearest; default build truncates.
module fp_encoder_pipe #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_s,
    output logic [EXP_W-1:0] out_e,
    output logic [MAN_W-1:0] out_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] sat_count
);
    localparam int STAGES = 3;
    localparam int MAG_W  = IN_W - 1;
    localparam int E_MAX  = (1 << EXP_W) - 1;
    localparam int SH_W   = MAG_W + MAN_W + 1;
`ifdef FPENC_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic                adv;
    logic [STAGES:1]     vld_pipe_d, vld_pipe_q;
    logic                s1_s_d, s1_s_q, s1_sat_d, s1_sat_q;
    logic [MAG_W-1:0]    s1_mag_d, s1_mag_q;
    logic                s2_s_d, s2_s_q, s2_sat_d, s2_sat_q, s2_r_d, s2_r_q;
    logic [EXP_W-1:0]    s2_e_d, s2_e_q;
    logic [MAN_W-1:0]    s2_m_d, s2_m_q;
    logic                out_s_d, out_s_q, out_sat_d, out_sat_q;
    logic [EXP_W-1:0]    out_e_d, out_e_q;
    logic [MAN_W-1:0]    out_m_d, out_m_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    int                  lead_pos, exp_raw;
    logic [SH_W-1:0]     sh;
    logic [MAN_W:0]      m_sum;

    always_comb begin
        adv        = !vld_pipe_q[STAGES] || out_ready;
        vld_pipe_d = vld_pipe_q;
        if (adv) vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
    end

    // Stage 1: magnitude; the most-negative code has no positive twin and saturates.
    always_comb begin
        s1_s_d   = in_data[IN_W-1];
        s1_sat_d = 1'b0;
        if (in_data == {1'b1, {MAG_W{1'b0}}}) begin
            s1_mag_d = '1;
            s1_sat_d = 1'b1;
        end else if (in_data[IN_W-1]) begin
            s1_mag_d = ~in_data[MAG_W-1:0] + MAG_W'(1);
        end else begin
            s1_mag_d = in_data[MAG_W-1:0];
        end
    end

    // Stage 2: shift {mag,0} right by E so bit 0 is the round bit and anything
    // left above the significand means the exponent clamp was too small.
    always_comb begin
        lead_pos = 0;
        for (int i = 0; i < MAG_W; i++)
            if (s1_mag_q[i]) lead_pos = i;
        exp_raw = lead_pos - (MAN_W - 1);
        if (exp_raw < 0) exp_raw = 0;
        if (exp_raw > E_MAX) exp_raw = E_MAX;
        s2_s_d   = s1_s_q;
        s2_e_d   = EXP_W'(exp_raw);
        sh       = SH_W'({s1_mag_q, 1'b0}) >> s2_e_d;
        s2_m_d   = sh[MAN_W:1];
        s2_r_d   = sh[0] & ROUND_EN;
        s2_sat_d = s1_sat_q | (|sh[SH_W-1:MAN_W+1]);
    end

    // Stage 3: round, renormalise on carry-out, then apply saturation.
    always_comb begin
        m_sum     = {1'b0, s2_m_q} + (MAN_W+1)'(s2_r_q);
        out_s_d   = s2_s_q;
        out_e_d   = s2_e_q;
        out_m_d   = m_sum[MAN_W-1:0];
        out_sat_d = s2_sat_q;
        if (m_sum[MAN_W]) begin
            out_m_d          = '0;
            out_m_d[MAN_W-1] = 1'b1;
            if (s2_e_q == EXP_W'(E_MAX)) out_sat_d = 1'b1;
            else                         out_e_d   = s2_e_q + EXP_W'(1);
        end
        if (out_sat_d) begin
            out_e_d = EXP_W'(E_MAX);
            out_m_d = '1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (vld_pipe_q[STAGES] && out_ready && out_sat_q && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_s_q     <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_mag_q   <= '0;
            s2_s_q     <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_r_q     <= 1'b0;
            s2_e_q     <= '0;
            s2_m_q     <= '0;
            out_s_q    <= 1'b0;
            out_sat_q  <= 1'b0;
            out_e_q    <= '0;
            out_m_q    <= '0;
            cnt_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
            if (adv) begin
                s1_s_q    <= s1_s_d;
                s1_sat_q  <= s1_sat_d;
                s1_mag_q  <= s1_mag_d;
                s2_s_q    <= s2_s_d;
                s2_sat_q  <= s2_sat_d;
                s2_r_q    <= s2_r_d;
                s2_e_q    <= s2_e_d;
                s2_m_q    <= s2_m_d;
                out_s_q   <= out_s_d;
                out_sat_q <= out_sat_d;
                out_e_q   <= out_e_d;
                out_m_q   <= out_m_d;
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_pipe_q[STAGES];
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_m     = out_m_q;
    assign sat_count = cnt_q;
endmodule

// File: tb/tb_fp_encoder_pipe.sv
// Scoreboard bench for fp_encoder_pipe: directed encodings, latency, saturation,
// backpressure, mid-stream reset and a random stream against an arithmetic model.
module tb_fp_encoder_pipe;
    localparam int IN_W  = 12;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int CNT_W = 8;
    localparam int E_MAX = (1 << EXP_W) - 1;
`ifdef FPENC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        logic             sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_data;
    logic             in_valid, in_ready;
    logic             out_s, out_valid, out_ready;
    logic [EXP_W-1:0] out_e;
    logic [MAN_W-1:0] out_m;
    logic [CNT_W-1:0] sat_count;

    exp_t             q[$];
    int               n_err = 0, n_chk = 0, exp_cnt = 0;
    bit               prev_stall = 1'b0, acc;
    int               n_out;
    logic [EXP_W+MAN_W:0] prev_f, f;

    fp_encoder_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_s(out_s), .out_e(out_e), .out_m(out_m), .out_valid(out_valid),
        .out_ready(out_ready), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [IN_W-1:0] x);
        exp_t r;
        int   mag, p, e, m, rb;
        logic sat;
        sat = 1'b0;
        r.s = x[IN_W-1];
        mag = x[IN_W-1] ? (1 << IN_W) - int'(x) : int'(x);
        if (mag == (1 << (IN_W - 1))) begin
            mag = mag - 1;
            sat = 1'b1;
        end
        p = 0;
        for (int i = 0; i < IN_W; i++)
            if (((mag >> i) & 1) != 0) p = i;
        e = p - (MAN_W - 1);
        if (e < 0) e = 0;
        m = 0;
        if (e > E_MAX) begin
            sat = 1'b1;
        end else begin
            m  = (mag >> e) % (1 << MAN_W);
            rb = (ROUND && e > 0) ? ((mag >> (e - 1)) & 1) : 0;
            m  = m + rb;
            if (m == (1 << MAN_W)) begin
                m = 1 << (MAN_W - 1);
                e = e + 1;
                if (e > E_MAX) sat = 1'b1;
            end
        end
        if (sat) begin
            e = E_MAX;
            m = (1 << MAN_W) - 1;
        end
        r.e   = EXP_W'(e);
        r.m   = MAN_W'(m);
        r.sat = sat;
        return r;
    endfunction

    // One clock: check at the falling edge, record handshakes, return #1 after the rising edge.
    task automatic step();
        exp_t x;
        @(negedge clk);
        chk("sat_count", 32'(sat_count), 32'(exp_cnt));
        if (prev_stall) chk("hold", 32'({out_valid, out_s, out_e, out_m}), 32'({1'b1, prev_f}));
        prev_stall = out_valid && !out_ready;
        prev_f     = {out_s, out_e, out_m};
        n_out = 0;
        acc   = 1'b0;
        if (out_valid && out_ready) begin
            n_out = 1;
            if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
            else begin
                x = q.pop_front();
                chk("out", 32'({out_s, out_e, out_m}), 32'({x.s, x.e, x.m}));
                if (x.sat && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
            end
        end
        if (in_valid && in_ready) begin
            acc = 1'b1;
            q.push_back(model(in_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_lat(input logic [IN_W-1:0] x, output logic [EXP_W+MAN_W:0] fo);
        int lat;
        in_data   = x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        fo = {out_s, out_e, out_m};
        step();
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 20) begin
            step();
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    function automatic logic [EXP_W+MAN_W:0] fld(input logic s, input int e, input int m);
        return {s, EXP_W'(e), MAN_W'(m)};
    endfunction

    initial begin
        logic [IN_W-1:0] bp[6];
        int k, n, acc_n, cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #3;
        chk("rst_state", 32'({out_valid, out_s, out_e, out_m, sat_count}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        send_lat(12'h090, f); chk("enc_144", 32'(f), 32'(fld(0, 4, 9)));
        send_lat(12'd5,   f); chk("enc_5",   32'(f), 32'(fld(0, 0, 5)));
        send_lat(12'hFFB, f); chk("enc_m5",  32'(f), 32'(fld(1, 0, 5)));
        send_lat(12'd0,   f); chk("enc_0",   32'(f), 32'(fld(0, 0, 0)));
        send_lat(12'd46,  f); chk("enc_46",  32'(f), ROUND ? 32'(fld(0, 2, 12)) : 32'(fld(0, 2, 11)));
        send_lat(12'd125, f); chk("enc_125", 32'(f), ROUND ? 32'(fld(0, 4, 8))  : 32'(fld(0, 3, 15)));
        chk("sat_pre", 32'(sat_count), 32'd0);
        send_lat(12'd2047, f); chk("enc_2047", 32'(f), 32'(fld(0, 7, 15)));
        chk("sat_one", 32'(sat_count), ROUND ? 32'd1 : 32'd0);
        send_lat(12'h800, f);  chk("enc_min",  32'(f), 32'(fld(1, 7, 15)));
        chk("sat_two", 32'(sat_count), ROUND ? 32'd2 : 32'd1);

        in_data = 12'h800; in_valid = 1'b1; out_ready = 1'b1;
        repeat (300) step();
        drain();
        chk("sat_sticky", 32'(sat_count), 32'd255);

        // Backpressure: three fill the pipe, then the rest wait for out_ready.
        bp[0] = 12'd100; bp[1] = 12'hF00; bp[2] = 12'd7; bp[3] = 12'd46; bp[4] = 12'd999; bp[5] = '0;
        out_ready = 1'b0; k = 0;
        for (int c = 0; c < 8; c++) begin
            in_data = bp[k]; in_valid = 1'b1;
            step();
            if (acc) k++;
        end
        chk("bp_accepted", 32'(k), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; n = 0;
        for (int c = 0; c < 5; c++) begin
            in_data = bp[k]; in_valid = (k < 5);
            step();
            if (acc) k++;
            n += n_out;
        end
        chk("bp_burst", 32'(n), 32'd5);
        drain();

        // Reset with three samples in flight.
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 12'(c * 37 + 5); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        q.delete(); exp_cnt = 0; prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send_lat(12'h090, f); chk("post_rst", 32'(f), 32'(fld(0, 4, 9)));

        // Random stream with random stalls.
        acc_n = 0; cyc = 0;
        while (acc_n < 10000 && cyc < 40000) begin
            in_data   = ($urandom_range(0, 7) == 0) ? 12'h800 : IN_W'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (acc) acc_n++;
            cyc++;
        end
        chk("rand_accepted", 32'(acc_n), 32'd10000);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
